// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, FSM state encoding and parity helper.
// Used by both uart_tx_fsm and uart_rx_fsm so the two directions agree on format.
package uart_pkg;

  localparam int DATA_BITS          = 8;
  localparam int OVERSAMPLE_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Even parity is the XOR of the data bits; odd parity is its complement.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_fsm_if.sv
// Byte handshake between a producer and the UART transmitter.
interface uart_tx_fsm_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, output tx_ready);

endinterface

// File: rtl/uart_tx_fsm.sv
// UART transmitter: one-entry holding register feeding a start/data/parity/stop
// serialiser that advances on the shared oversampling tick enable.
module uart_tx_fsm
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  uart_tx_fsm_if.slave  tx_if,
  output logic          tx,
  output logic          tx_busy,
  output logic          tx_done
);

  localparam int TW = $clog2(OVERSAMPLE);

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_START  = START;
  localparam logic [2:0] S_DATA   = DATA;
  localparam logic [2:0] S_PARITY = PARITY;
  localparam logic [2:0] S_STOP   = STOP;

  logic [2:0]           state;
  logic [TW-1:0]        tick_cnt;
  logic [2:0]           bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] hold;
  logic                 hold_full;
  logic [DATA_BITS-1:0] shift;
  logic                 par;

  logic accept;
  logic bit_end;
  logic last_stop;
  logic load;

  assign tx_if.tx_ready = !hold_full;
  assign tx_busy        = (state != S_IDLE);
  assign accept         = tx_if.tx_valid && !hold_full;
  assign bit_end        = tick && (tick_cnt == TW'(OVERSAMPLE - 1));
  assign last_stop      = (stop_idx == 1'(STOP_BITS - 1));
  // A frame starts either from idle or straight out of the final stop tick.
  assign load           = hold_full &&
                          ((state == S_IDLE) || (state == S_STOP && bit_end && last_stop));

  // Holding register occupancy: filled by a handshake, emptied when the FSM loads it.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_full <= 1'b0;
    end else if (accept) begin
      hold_full <= 1'b1;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  // Data payload registers: holding byte, shift register and the parity captured at load.
  // NOTE: pure data registers carry no reset; they are only consumed once a reset flag marks them valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold <= tx_if.tx_data;
    end
    if (load) begin
      shift <= hold;
      par   <= parity_bit(hold, 1'(PARITY_ODD));
    end else if (state == S_DATA && bit_end) begin
      shift <= {1'b0, shift[DATA_BITS-1:1]};
    end
  end

  // Frame sequencer: bit timing, state transitions and the registered serial line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (state != S_IDLE && tick) begin
        tick_cnt <= bit_end ? {TW{1'b0}} : tick_cnt + 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (load) begin
            state    <= S_START;
            tx       <= 1'b0;
            tick_cnt <= '0;
            bit_idx  <= '0;
          end
        end
        S_START: begin
          if (bit_end) begin
            state <= S_DATA;
            tx    <= shift[0];
          end
        end
        S_DATA: begin
          if (bit_end) begin
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
              stop_idx <= 1'b0;
              if (PARITY_EN != 0) begin
                state <= S_PARITY;
                tx    <= par;
              end else begin
                state <= S_STOP;
                tx    <= 1'b1;
              end
            end else begin
              tx <= shift[1];
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            state    <= S_STOP;
            tx       <= 1'b1;
            stop_idx <= 1'b0;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (last_stop) begin
              tx_done <= 1'b1;
              if (load) begin
                state   <= S_START;
                tx      <= 1'b0;
                bit_idx <= '0;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              stop_idx <= stop_idx + 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_fsm.md
# uart_tx_fsm

Serial UART transmitter; the transmit-side counterpart of the team's `uart_rx_fsm`, using the same frame format and 16x tick.
- Accepts bytes over a valid/ready handshake into a one-entry holding register.
- Serialises each byte as: start bit, 8 data bits LSB first, optional parity bit, 1 or 2 stop bits.
- Advances on the shared oversampling `tick` enable, so one baud generator drives both directions.

## Interface
- OVERSAMPLE, 16: ticks per bit; must be ≥ 2.
- PARITY_EN, 1: 1 inserts a parity bit after data; 0 omits it.
- PARITY_ODD, 0: 0 selects even parity (bit = ^data); 1 selects odd (bit = ~^data).
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- tick  in  1  single-cycle enable pulse at OVERSAMPLE x baud, synchronous to clk.
- tx_data  in  8  byte to send; sampled on handshake.
- tx_valid  in  1  producer has a byte.
- tx_ready  out  1  holding register empty; a transfer occurs when tx_valid && tx_ready at a clk edge.
- tx  out  1  serial line; idle high; registered output.
- tx_busy  out  1  high whenever the FSM is not IDLE.
- tx_done  out  1  one-cycle pulse on the final tick of the last stop bit.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Reset values: tx=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, hold empty, counters 0.
- **Holding register.** On handshake, tx_data is loaded into hold and hold_full is set. tx_ready = !hold_full.
- **IDLE → START.** In IDLE with hold_full, the next edge does all of:
  - copy hold into the shift register;
  - compute and store the parity bit;
  - clear hold_full;
  - clear tick_cnt and bit_idx;
  - enter START with tx=0.
- **Bit timing.** tick_cnt increments on each tick. On a tick with tick_cnt == OVERSAMPLE-1, tick_cnt wraps to 0 and the bit ends.
- **START** ends → DATA, with tx = shift[0].
- **DATA:** at each bit end, shift right and increment bit_idx. After bit_idx 7 ends:
  - → PARITY (tx = parity bit) when PARITY_EN=1;
  - → STOP (tx=1) otherwise.
- **PARITY** ends → STOP, tx=1.
- **STOP:** lasts STOP_BITS bit times; a stop-bit counter tracks this. On the final tick:
  - tx_done pulses;
  - if hold_full, go directly to START (tx=0, hold popped as above), giving back-to-back frames with no idle gap;
  - otherwise go to IDLE.
- **Data stability.** The shift register is never modified by new handshakes. A byte accepted mid-frame waits in hold.
- **Concurrency.** A handshake and a pop never coincide, because tx_ready=0 while hold is full.
- **tick ignored in IDLE.** tick_cnt stays 0.
- **Reset mid-frame.** tx goes to 1 immediately (asynchronous). The hold byte is discarded and the FSM returns to IDLE. No tx_done is emitted.

## Timing
- Handshake at edge N → tx=0 from edge N+1 (FSM idle, hold previously empty). tx_ready is low for exactly one cycle.
- START begins at an arbitrary phase relative to tick, so the start bit lasts between OVERSAMPLE-1 and OVERSAMPLE tick periods. Every later bit is exactly OVERSAMPLE ticks.
- Frame length = OVERSAMPLE x (1 + 8 + PARITY_EN + STOP_BITS) ticks. With default parameters this is 176 ticks.
- tick_cnt width is $clog2(OVERSAMPLE). bit_idx is 3 bits. Parity is an 8-bit XOR reduction, registered at load.
- tx_done coincides with the clk edge that leaves STOP.

## Structure
- Shared package `uart_pkg`, also used by `uart_rx_fsm`, holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - DATA_BITS=8;
  - the default OVERSAMPLE;
  - a parity function taking (data, odd) and returning the parity bit.
- Single module; the holding register and FSM are inline. No sub-module is warranted.
- Integration check: `uart_tx_fsm` loops back into `uart_rx_fsm` with a shared tick.

## Test plan
1. **Single byte.** tick every clk, defaults; send 0xA5 → tx shows 0, 1,0,1,0,0,1,0,1, parity 0, stop 1, each bit 16 cycles; tx_done pulses once; tx_busy falls on the same edge.
2. **Parity.** Send 0x01 with even parity → parity bit 1. Repeat with PARITY_ODD=1 → parity bit 0. Repeat with PARITY_EN=0 → frame is 10 bits (160 ticks).
3. **Back-to-back.** Hold tx_valid high with 0x5A then 0x99 → second start bit follows the first stop bit with zero idle cycles; tx_ready low throughout frame 1 after the second accept.
4. **Two stop bits.** STOP_BITS=2; send 0x99 → tx high for 32 ticks after parity; tx_done on the final tick.
5. **Slow tick.** Tick every 4 clk; send 0x3C → each bit lasts 64 clk (start bit 61–64 clk); loopback to `uart_rx_fsm` yields rx_data=0x3C with no errors.
6. **Reset mid-frame.** Assert rst during data bit 3 with a byte in hold → tx=1 asynchronously; after release tx_ready=1, tx_busy=0, no frame transmitted.
